axi_burst_scheduler: RTL and testbench
======================================

// Module: axi_burst_scheduler
// PURPOSE
//  Serialises write and read bursts onto one shared AXI4 slave (BRAM/DDR) used as a circular burst store.
//  Arbitrates the write engine (FIFO holds a full burst) against user read requests, one transaction in flight.
//  Generates ring addresses between base and final address and tracks fill level so reads never overtake writes.
//  Sits in axi_top between the user FIFOs and the AW/W/B and AR/R channel engines.
// PARAMETERS
//  P_AXI_ADDR_WIDTH  32   AXI byte-address width
//  P_AXI_DATA_WIDTH  128  AXI data width; beat bytes = P_AXI_DATA_WIDTH/8
//  P_BURST_BEATS     256  beats per burst; burst bytes BB = P_BURST_BEATS*P_AXI_DATA_WIDTH/8 (4096)
//  P_FILL_WIDTH      16   width of the fill counter
// PORTS
//  i_axi_clk        in   1   sole clock
//  i_rst            in   1   synchronous, active-high reset
//  i_ddr_init       in   1   memory calibrated/ready
//  i_ring_baddr     in   AW  ring base byte address
//  i_ring_faddr     in   AW  ring final (exclusive) byte address
//  i_wr_req         in   1   level: write FIFO holds >= one full burst
//  o_wr_cmd_valid   out  1   write-burst command valid
//  o_wr_cmd_addr    out  AW  write-burst start address
//  i_wr_cmd_ready   in   1   write engine accepts command
//  i_wr_done        in   1   pulse: B response accepted (bvalid&bready)
//  i_rd_req         in   1   pulse: user requests one burst
//  o_rd_cmd_valid   out  1   read-burst command valid
//  o_rd_cmd_addr    out  AW  read-burst start address
//  i_rd_cmd_ready   in   1   read engine accepts command
//  i_rd_done        in   1   pulse: rlast beat accepted
//  o_rd_busy        out  1   read request pending or in flight
//  o_rd_drop        out  1   pulse: i_rd_req ignored (already busy)
//  o_fill           out  FW  bursts stored, not yet read
//  o_full / o_empty out  1   fill == capacity / fill == 0
//  o_cfg_err        out  1   latched config invalid
// BEHAVIOUR
//  Reset: all outputs 0, except o_empty=1; FSM=CFG, pointers/fill cleared, pending-read cleared.
//  CFG: while i_ddr_init=1, latch baddr/faddr once; CAP=(faddr-baddr)/BB. Error if faddr<=baddr, baddr or faddr not BB-aligned,
//   or CAP > 2^FW-1. On error: o_cfg_err=1, stay in CFG until reset. Otherwise wr_ptr=rd_ptr=baddr -> IDLE.
//  Read request: i_rd_req while !o_rd_busy sets rd_pend and o_rd_busy (next cycle); i_rd_req while busy pulses o_rd_drop 1 cycle.
//   o_rd_busy clears the cycle after i_rd_done.
//  IDLE eligibility: we = i_wr_req & !o_full; re = rd_pend & !o_empty. Only we -> write; only re -> read.
//   Both -> round-robin: grant the side not served last (last_wr flag, reset 0, so a write wins the first tie).
//  WR_CMD: o_wr_cmd_valid=1 with o_wr_cmd_addr=wr_ptr, held stable until i_wr_cmd_ready; -> WR_WAIT.
//  WR_WAIT: on i_wr_done: fill+1, wr_ptr+=BB (wrap to baddr when the result == faddr); -> IDLE.
//  RD_CMD / RD_WAIT: same pattern with rd_ptr; on i_rd_done: fill-1, rd_ptr advance/wrap, rd_pend=0; -> IDLE.
//  Latency: the IDLE grant decision is made in 1 cycle; cmd_valid is asserted in the next cycle.
//   After a done pulse, the next grant is evaluated in the cycle after that.
//  Done pulses outside the matching WAIT state are ignored. Fill never overflows or underflows, by the eligibility rule.
//  o_full/o_empty/o_fill are registered, updated the cycle after a done pulse.
//  i_rst mid-burst drops cmd_valid the next cycle; all state returns to CFG (engines are reset by the same i_rst).
//  Address arithmetic at AW bits; BB is added as a constant; the compare against faddr is equality only (alignment is guaranteed by CFG).
// STRUCTURE
//  axi_sched_pkg: FSM state enum (CFG, IDLE, WR_CMD, WR_WAIT, RD_CMD, RD_WAIT), localparam BB, and helper for CAP width.
//  Sub-module axi_ring_ptr (clk, rst, load, base, final, adv -> ptr) instantiated for wr_ptr and rd_ptr. The rest of the logic is flat.
// TESTING
//  1 base=0, final=0x14000, ddr_init=1 -> CAP=20, no cfg_err, o_empty=1, FSM in IDLE within 2 cycles.
//  2 wr_req held, ready/done immediate -> 20 cmds at 0x0..0x13000 step 0x1000, then o_full=1 and no 21st cmd.
//  3 Full ring, rd_req pulses -> rd addrs 0x0,0x1000..; after the 20th read o_empty=1; a further rd_req stays pending until a write.
//  4 wr_req held and rd_req pending with fill=5 -> grants alternate W,R,W,R; fill oscillates 5/6.
//  5 Write pointer at 0x13000, done -> next wr addr 0x0 (wrap); the read pointer wraps identically.
//  6 final=0x14800 (unaligned) -> o_cfg_err=1, no cmds; i_rst mid WR_WAIT -> cmd_valid low next cycle, fill=0.

Source files
------------

// File: rtl/axi_sched_pkg.sv
// axi_sched_pkg: FSM encodings and size helpers shared by the burst scheduler files
package axi_sched_pkg;

    localparam logic [2:0] ST_CFG     = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_WR_CMD  = 3'd2;
    localparam logic [2:0] ST_WR_WAIT = 3'd3;
    localparam logic [2:0] ST_RD_CMD  = 3'd4;
    localparam logic [2:0] ST_RD_WAIT = 3'd5;

    function automatic int burst_bytes(input int beats, input int data_width);
        return beats * data_width / 8;
    endfunction

    // A span with any bit set at or above this position holds more bursts than the fill counter can count
    function automatic int cap_shift(input int bb, input int fill_width);
        return $clog2(bb) + fill_width;
    endfunction

endpackage

// File: rtl/axi_ring_ptr.sv
// axi_ring_ptr: burst-granular ring pointer that wraps from the final address back to the base
module axi_ring_ptr #(
    parameter int P_AW = 32,
    parameter int P_BB = 4096
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [P_AW-1:0] i_base,
    input  logic [P_AW-1:0] i_final,
    input  logic            i_adv,
    output logic [P_AW-1:0] o_ptr
);
    logic [P_AW-1:0] r_ptr;
    logic [P_AW-1:0] w_next;

    assign w_next = r_ptr + P_AW'(P_BB);
    assign o_ptr  = r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_ptr <= '0;
        else if (i_load)
            r_ptr <= i_base;
        else if (i_adv)
            r_ptr <= (w_next == i_final) ? i_base : w_next;
    end

endmodule

// File: rtl/axi_burst_scheduler.sv
// axi_burst_scheduler: serialises write and read bursts onto one AXI slave used as a circular burst store
module axi_burst_scheduler
    import axi_sched_pkg::*;
#(
    parameter int P_AXI_ADDR_WIDTH = 32,
    parameter int P_AXI_DATA_WIDTH = 128,
    parameter int P_BURST_BEATS    = 256,
    parameter int P_FILL_WIDTH     = 16
) (
    input  logic                        i_axi_clk,
    input  logic                        i_rst,
    input  logic                        i_ddr_init,
    input  logic [P_AXI_ADDR_WIDTH-1:0] i_ring_baddr,
    input  logic [P_AXI_ADDR_WIDTH-1:0] i_ring_faddr,
    input  logic                        i_wr_req,
    output logic                        o_wr_cmd_valid,
    output logic [P_AXI_ADDR_WIDTH-1:0] o_wr_cmd_addr,
    input  logic                        i_wr_cmd_ready,
    input  logic                        i_wr_done,
    input  logic                        i_rd_req,
    output logic                        o_rd_cmd_valid,
    output logic [P_AXI_ADDR_WIDTH-1:0] o_rd_cmd_addr,
    input  logic                        i_rd_cmd_ready,
    input  logic                        i_rd_done,
    output logic                        o_rd_busy,
    output logic                        o_rd_drop,
    output logic [P_FILL_WIDTH-1:0]     o_fill,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_cfg_err
);
    localparam int LP_BB     = burst_bytes(P_BURST_BEATS, P_AXI_DATA_WIDTH);
    localparam int LP_LB     = $clog2(LP_BB);
    localparam int LP_CAP_SH = cap_shift(LP_BB, P_FILL_WIDTH);

    logic [2:0]                  r_state, w_state_nx;
    logic [P_AXI_ADDR_WIDTH-1:0] r_baddr, r_faddr, w_base, w_span, w_wr_ptr, w_rd_ptr;
    logic [P_FILL_WIDTH-1:0]     r_fill, r_cap, w_fill_nx;
    logic                        r_cfg_err, r_rd_pend, r_rd_drop, r_last_wr, r_full, r_empty;
    logic                        w_cfg_go, w_cfg_bad, w_load, w_we, w_re, w_wr_adv, w_rd_adv;

    assign w_span    = i_ring_faddr - i_ring_baddr;
    assign w_cfg_go  = (r_state == ST_CFG) && i_ddr_init && !r_cfg_err;
    assign w_cfg_bad = (i_ring_faddr <= i_ring_baddr) || (i_ring_baddr[LP_LB-1:0] != '0) ||
                       (i_ring_faddr[LP_LB-1:0] != '0) || ((w_span >> LP_CAP_SH) != '0);
    assign w_load    = w_cfg_go && !w_cfg_bad;
    // Pointers load in the same cycle the ring bounds are latched, so take the base straight from the port
    assign w_base    = (r_state == ST_CFG) ? i_ring_baddr : r_baddr;
    assign w_we      = i_wr_req && !r_full;
    assign w_re      = r_rd_pend && !r_empty;
    assign w_wr_adv  = (r_state == ST_WR_WAIT) && i_wr_done;
    assign w_rd_adv  = (r_state == ST_RD_WAIT) && i_rd_done;
    assign w_fill_nx = r_fill + P_FILL_WIDTH'(w_wr_adv) - P_FILL_WIDTH'(w_rd_adv);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_CFG:     w_state_nx = w_load ? ST_IDLE : ST_CFG;
            ST_IDLE:    w_state_nx = (w_we && (!w_re || !r_last_wr)) ? ST_WR_CMD : w_re ? ST_RD_CMD : ST_IDLE;
            ST_WR_CMD:  w_state_nx = i_wr_cmd_ready ? ST_WR_WAIT : ST_WR_CMD;
            ST_WR_WAIT: w_state_nx = i_wr_done ? ST_IDLE : ST_WR_WAIT;
            ST_RD_CMD:  w_state_nx = i_rd_cmd_ready ? ST_RD_WAIT : ST_RD_CMD;
            ST_RD_WAIT: w_state_nx = i_rd_done ? ST_IDLE : ST_RD_WAIT;
            default:    w_state_nx = ST_CFG;
        endcase
    end

    always_ff @(posedge i_axi_clk) begin
        if (i_rst) begin
            r_state   <= ST_CFG;
            r_baddr   <= '0;
            r_faddr   <= '0;
            r_cap     <= '0;
            r_cfg_err <= 1'b0;
            r_fill    <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_rd_pend <= 1'b0;
            r_rd_drop <= 1'b0;
            r_last_wr <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_rd_drop <= i_rd_req && r_rd_pend;
            if (w_cfg_go) begin
                r_baddr   <= i_ring_baddr;
                r_faddr   <= i_ring_faddr;
                r_cap     <= P_FILL_WIDTH'(w_span >> LP_LB);
                r_cfg_err <= w_cfg_bad;
            end
            if (i_rd_req && !r_rd_pend)
                r_rd_pend <= 1'b1;
            else if (w_rd_adv)
                r_rd_pend <= 1'b0;
            if ((r_state == ST_IDLE) && (w_state_nx != ST_IDLE))
                r_last_wr <= (w_state_nx == ST_WR_CMD);
            r_fill  <= w_fill_nx;
            r_full  <= (r_state != ST_CFG) && (w_fill_nx == r_cap);
            r_empty <= (w_fill_nx == '0);
        end
    end

    axi_ring_ptr #(.P_AW(P_AXI_ADDR_WIDTH), .P_BB(LP_BB)) u_wr_ptr (
        .i_clk(i_axi_clk), .i_rst(i_rst), .i_load(w_load), .i_base(w_base),
        .i_final(r_faddr), .i_adv(w_wr_adv), .o_ptr(w_wr_ptr)
    );

    axi_ring_ptr #(.P_AW(P_AXI_ADDR_WIDTH), .P_BB(LP_BB)) u_rd_ptr (
        .i_clk(i_axi_clk), .i_rst(i_rst), .i_load(w_load), .i_base(w_base),
        .i_final(r_faddr), .i_adv(w_rd_adv), .o_ptr(w_rd_ptr)
    );

    assign o_wr_cmd_valid = (r_state == ST_WR_CMD);
    assign o_wr_cmd_addr  = w_wr_ptr;
    assign o_rd_cmd_valid = (r_state == ST_RD_CMD);
    assign o_rd_cmd_addr  = w_rd_ptr;
    assign o_rd_busy      = r_rd_pend;
    assign o_rd_drop      = r_rd_drop;
    assign o_fill         = r_fill;
    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_axi_burst_scheduler.sv
// tb_axi_burst_scheduler: directed table and sequence checks of the ring burst scheduler
module tb_axi_burst_scheduler;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1, i_ddr_init = 1'b0, i_wr_req = 1'b0, i_rd_req = 1'b0;
    logic [31:0] i_ring_baddr = '0, i_ring_faddr = '0;
    logic        i_wr_cmd_ready = 1'b1, i_rd_cmd_ready = 1'b1, i_wr_done = 1'b0, i_rd_done = 1'b0;
    logic        o_wr_cmd_valid, o_rd_cmd_valid, o_rd_busy, o_rd_drop, o_full, o_empty, o_cfg_err;
    logic [31:0] o_wr_cmd_addr, o_rd_cmd_addr;
    logic [15:0] o_fill;

    int          checks = 0, errors = 0;
    logic [31:0] wr_log[$], rd_log[$];
    bit          grants[$];
    logic        auto_wr = 1'b1, wr_fire = 1'b0, rd_fire = 1'b0, spur_rd = 1'b0, track = 1'b0;
    int          fmin = 999, fmax = 0;

    typedef struct {
        logic [31:0] base;
        logic [31:0] fin;
        logic        exp_err;
        logic [31:0] exp_addr;
    } cfg_vec_t;
    cfg_vec_t tv[8];

    always #5 clk = ~clk;

    axi_burst_scheduler dut (
        .i_axi_clk(clk), .i_rst(i_rst), .i_ddr_init(i_ddr_init),
        .i_ring_baddr(i_ring_baddr), .i_ring_faddr(i_ring_faddr),
        .i_wr_req(i_wr_req), .o_wr_cmd_valid(o_wr_cmd_valid), .o_wr_cmd_addr(o_wr_cmd_addr),
        .i_wr_cmd_ready(i_wr_cmd_ready), .i_wr_done(i_wr_done),
        .i_rd_req(i_rd_req), .o_rd_cmd_valid(o_rd_cmd_valid), .o_rd_cmd_addr(o_rd_cmd_addr),
        .i_rd_cmd_ready(i_rd_cmd_ready), .i_rd_done(i_rd_done),
        .o_rd_busy(o_rd_busy), .o_rd_drop(o_rd_drop), .o_fill(o_fill),
        .o_full(o_full), .o_empty(o_empty), .o_cfg_err(o_cfg_err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Engine model: a handshake seen at a negedge completes on the next posedge, done follows one cycle later
    initial forever begin
        @(negedge clk);
        i_wr_done = wr_fire;
        i_rd_done = rd_fire | spur_rd;
        wr_fire   = o_wr_cmd_valid & i_wr_cmd_ready & auto_wr;
        rd_fire   = o_rd_cmd_valid & i_rd_cmd_ready;
        if (o_wr_cmd_valid && i_wr_cmd_ready) begin
            wr_log.push_back(o_wr_cmd_addr);
            grants.push_back(1'b1);
        end
        if (o_rd_cmd_valid && i_rd_cmd_ready) begin
            rd_log.push_back(o_rd_cmd_addr);
            grants.push_back(1'b0);
        end
        if (track) begin
            if (int'(o_fill) < fmin) fmin = int'(o_fill);
            if (int'(o_fill) > fmax) fmax = int'(o_fill);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1; i_wr_req = 1'b0; i_rd_req = 1'b0; i_ddr_init = 1'b0; auto_wr = 1'b1; i_wr_cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        wr_log.delete(); rd_log.delete(); grants.delete();
    endtask

    task automatic cfg(input logic [31:0] b, input logic [31:0] f);
        i_ring_baddr = b; i_ring_faddr = f; i_ddr_init = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_rd();
        i_rd_req = 1'b1;
        @(negedge clk);
        i_rd_req = 1'b0;
    endtask

    task automatic wait_wr(input int n, input int lim, input string name);
        for (int k = 0; k < lim && wr_log.size() < n; k++) @(negedge clk);
        chk(name, 32'(wr_log.size() >= n), 1);
    endtask

    task automatic wait_rd(input int n, input int lim, input string name);
        for (int k = 0; k < lim && rd_log.size() < n; k++) @(negedge clk);
        chk(name, 32'(rd_log.size() >= n), 1);
    endtask

    task automatic wait_not_busy(input string name);
        for (int k = 0; k < 20 && o_rd_busy; k++) @(negedge clk);
        chk(name, 32'(o_rd_busy), 0);
    endtask

    initial begin
        int g0;
        tv[0] = '{32'h0,     32'h14000,    1'b0, 32'h0};
        tv[1] = '{32'h0,     32'h14800,    1'b1, 32'h0};
        tv[2] = '{32'h14000, 32'h14000,    1'b1, 32'h0};
        tv[3] = '{32'h15000, 32'h14000,    1'b1, 32'h0};
        tv[4] = '{32'h800,   32'h14000,    1'b1, 32'h0};
        tv[5] = '{32'h3000,  32'h8000,     1'b0, 32'h3000};
        tv[6] = '{32'h0,     32'h10000000, 1'b1, 32'h0};
        tv[7] = '{32'h1000,  32'h10000000, 1'b0, 32'h1000};

        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(o_empty), 1);
        chk("rst_full", 32'(o_full), 0);
        chk("rst_fill", 32'(o_fill), 0);
        chk("rst_cfg_err", 32'(o_cfg_err), 0);
        chk("rst_wr_valid", 32'(o_wr_cmd_valid), 0);
        chk("rst_rd_busy", 32'(o_rd_busy), 0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            cfg(tv[i].base, tv[i].fin);
            chk($sformatf("cfg%0d_err", i), 32'(o_cfg_err), 32'(tv[i].exp_err));
            chk($sformatf("cfg%0d_empty", i), 32'(o_empty), 1);
            i_wr_req = 1'b1;
            repeat (8) @(negedge clk);
            i_wr_req = 1'b0;
            chk($sformatf("cfg%0d_cmd", i), 32'(wr_log.size() != 0), 32'(!tv[i].exp_err));
            if (wr_log.size() != 0) chk($sformatf("cfg%0d_addr", i), wr_log[0], tv[i].exp_addr);
        end

        do_reset();
        cfg(32'h0, 32'h14000);
        chk("ring_cfg_err", 32'(o_cfg_err), 0);
        chk("ring_empty", 32'(o_empty), 1);

        i_wr_req = 1'b1;
        wait_wr(20, 120, "fill_wait");
        repeat (12) @(negedge clk);
        chk("full_flag", 32'(o_full), 1);
        chk("full_fill", 32'(o_fill), 20);
        chk("full_not_empty", 32'(o_empty), 0);
        chk("no_21st_wr", 32'(wr_log.size()), 20);
        for (int i = 0; i < 20 && i < wr_log.size(); i++) chk($sformatf("wr_addr%0d", i), wr_log[i], 32'(i * 32'h1000));
        i_wr_req = 1'b0;

        for (int i = 0; i < 20; i++) begin
            pulse_rd();
            wait_rd(i + 1, 20, "rd_wait");
            wait_not_busy("rd_busy_clear");
        end
        for (int i = 0; i < 20 && i < rd_log.size(); i++) chk($sformatf("rd_addr%0d", i), rd_log[i], 32'(i * 32'h1000));
        chk("drain_empty", 32'(o_empty), 1);
        chk("drain_fill", 32'(o_fill), 0);

        pulse_rd();
        chk("pend_busy", 32'(o_rd_busy), 1);
        i_rd_req = 1'b1;
        @(negedge clk);
        i_rd_req = 1'b0;
        chk("drop_pulse", 32'(o_rd_drop), 1);
        @(negedge clk);
        chk("drop_clear", 32'(o_rd_drop), 0);
        repeat (8) @(negedge clk);
        chk("pend_no_rd", 32'(rd_log.size()), 20);
        chk("pend_still_busy", 32'(o_rd_busy), 1);

        i_wr_req = 1'b1;
        wait_rd(21, 40, "pend_served");
        i_wr_req = 1'b0;
        wait_not_busy("pend_busy_clear");
        chk("wr_wrap_addr", wr_log.size() > 20 ? wr_log[20] : 32'hdead, 32'h0);
        chk("rd_wrap_addr", rd_log.size() > 20 ? rd_log[20] : 32'hdead, 32'h0);
        chk("wrap_wr_count", 32'(wr_log.size()), 21);
        chk("wrap_empty", 32'(o_empty), 1);

        i_wr_req = 1'b1;
        wait_wr(26, 40, "prefill_wait");
        i_wr_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("prefill_fill", 32'(o_fill), 5);

        g0 = grants.size();
        track = 1'b1;
        i_wr_req = 1'b1;
        for (int r = 0; r < 4; r++) begin
            pulse_rd();
            wait_rd(22 + r, 40, "rr_rd_wait");
            if (r == 3) i_wr_req = 1'b0;
            wait_not_busy("rr_busy_clear");
        end
        repeat (6) @(negedge clk);
        track = 1'b0;
        chk("rr_grant_count", 32'(grants.size() - g0), 8);
        for (int j = 0; j < 8 && g0 + j < grants.size(); j++) chk($sformatf("rr_grant%0d", j), 32'(grants[g0 + j]), 32'(j % 2 == 0));
        chk("rr_fill_min", 32'(fmin), 5);
        chk("rr_fill_max", 32'(fmax), 6);
        chk("rr_fill_end", 32'(o_fill), 5);
        chk("rr_first_rd", rd_log.size() > 21 ? rd_log[21] : 32'hdead, 32'h1000);

        do_reset();
        cfg(32'h0, 32'h14000);
        i_wr_cmd_ready = 1'b0;
        i_wr_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("hold_valid", 32'(o_wr_cmd_valid), 1);
        chk("hold_addr", o_wr_cmd_addr, 32'h0);
        repeat (2) @(negedge clk);
        chk("hold_valid2", 32'(o_wr_cmd_valid), 1);
        auto_wr = 1'b0;
        @(posedge clk); #1;
        i_wr_cmd_ready = 1'b1;
        @(posedge clk); #1;
        i_wr_req = 1'b0;
        spur_rd = 1'b1;
        @(posedge clk); #1;
        spur_rd = 1'b0;
        @(negedge clk);
        chk("wait_valid_low", 32'(o_wr_cmd_valid), 0);
        chk("spur_done_fill", 32'(o_fill), 0);
        chk("spur_done_empty", 32'(o_empty), 1);
        chk("wait_one_cmd", 32'(wr_log.size()), 1);
        i_rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 32'(o_wr_cmd_valid), 0);
        chk("rst_mid_fill", 32'(o_fill), 0);
        chk("rst_mid_empty", 32'(o_empty), 1);
        i_rst = 1'b0;
        auto_wr = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
